// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the AsyncFIFO read-side consumer.
// The state enum is also used by anything that observes the controller's debug state.
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } rd_state_e;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_SKID_DEPTH = 2;
   localparam int DEF_CNT_WIDTH  = 16;

   // Occupancy must represent 0..depth inclusive.
   function automatic int skid_occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// DEPTH-entry circular skid buffer; dout_o is the head entry, valid_o means occ_o != 0.
// The caller never pushes when full and never pops when empty.
module fifo_rd_skid #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 2,
   parameter int OCC_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] dout_o,
   output logic [OCC_WIDTH-1:0]  occ_o,
   output logic                  valid_o
);

   localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_WIDTH-1:0]  wr_q, wr_d;
   logic [PTR_WIDTH-1:0]  rd_q, rd_d;
   logic [OCC_WIDTH-1:0]  occ_q, occ_d;

   // Pointers wrap explicitly so non-power-of-two depths work too.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      occ_d = occ_q;
      if (push_i) begin
         wr_d = (wr_q == LAST_PTR) ? '0 : wr_q + PTR_WIDTH'(1);
      end
      if (pop_i) begin
         rd_d = (rd_q == LAST_PTR) ? '0 : rd_q + PTR_WIDTH'(1);
      end
      if (push_i && !pop_i) begin
         occ_d = occ_q + OCC_WIDTH'(1);
      end else if (!push_i && pop_i) begin
         occ_d = occ_q - OCC_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         occ_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         occ_q <= occ_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_i) begin
         mem_q[wr_q] <= din_i;
      end
   end

   assign dout_o  = mem_q[rd_q];
   assign occ_o   = occ_q;
   assign valid_o = (occ_q != '0);

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain consumer for the AsyncFIFO: pops entries, captures data_out a cycle later,
// and re-presents them as a valid/ready stream through a small skid buffer.
module fifo_read_ctrl
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int SKID_DEPTH = DEF_SKID_DEPTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk_read,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  empty,
   input  logic                  almost_empty,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  read_enable,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic                  underflow_err,
   output rd_state_e             dbg_state
);

   // Stream handshake: a beat moves when m_valid && m_ready at a rising edge; while m_valid
   // is high and m_ready low, m_data holds. m_ready may combinationally affect read_enable.

   localparam int OCC_WIDTH = skid_occ_width(SKID_DEPTH);

   rd_state_e              state_q;
   logic                   inflight_q;
   logic                   ae_guard_q, ae_guard_d;
   logic [CNT_WIDTH-1:0]   rd_count_q, rd_count_d;
   logic                   underflow_q, underflow_d;

   logic [OCC_WIDTH-1:0]   occ;
   logic [OCC_WIDTH:0]     budget;
   logic                   pop;
   logic                   deliver;
   logic                   skid_valid;
   logic [DATA_WIDTH-1:0]  skid_head;

   fifo_rd_skid #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (SKID_DEPTH),
      .OCC_WIDTH  (OCC_WIDTH)
   ) u_skid (
      .clk_i   (clk_read),
      .rst_ni  (rst),
      .push_i  (inflight_q),
      .din_i   (data_out),
      .pop_i   (deliver),
      .dout_o  (skid_head),
      .occ_o   (occ),
      .valid_o (skid_valid)
   );

   assign deliver = skid_valid && m_ready;

   // Entries still owed a slot once this cycle's deliver and the pending capture settle.
   always_comb begin
      budget = {1'b0, occ}
             - {{OCC_WIDTH{1'b0}}, deliver}
             + {{OCC_WIDTH{1'b0}}, inflight_q};
      read_enable = (state_q == STREAM) && !empty && !ae_guard_q
                    && (budget < (OCC_WIDTH + 1)'(SKID_DEPTH));
   end

   assign pop = read_enable && !empty;

   always_comb begin
      ae_guard_d  = pop && almost_empty;
      rd_count_d  = rd_count_q + CNT_WIDTH'(deliver);
      underflow_d = underflow_q || (read_enable && empty);
   end

   always_ff @(posedge clk_read or negedge rst) begin
      if (!rst) begin
         inflight_q  <= 1'b0;
         ae_guard_q  <= 1'b0;
         rd_count_q  <= '0;
         underflow_q <= 1'b0;
      end else begin
         inflight_q  <= pop;
         ae_guard_q  <= ae_guard_d;
         rd_count_q  <= rd_count_d;
         underflow_q <= underflow_d;
      end
   end

   // DRAIN keeps delivering until the capture pipeline and skid are both empty.
   always_ff @(posedge clk_read or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (enable) state_q <= STREAM;
            end
            STREAM: begin
               if (!enable) state_q <= DRAIN;
            end
            DRAIN: begin
               if (enable) begin
                  state_q <= STREAM;
               end else if ((occ == '0) && !inflight_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m_valid       = skid_valid;
   assign m_data        = skid_head;
   assign rd_count      = rd_count_q;
   assign underflow_err = underflow_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: an ideal FIFO environment, a queue-based reference
// model compared every cycle, and hand-computed expectations for each scenario.
module tb_fifo_read_ctrl;
  import fifo_rd_pkg::*;

  localparam int DW = 8;
  localparam int SD = 2;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk_read = 1'b0;
  always #5 clk_read = ~clk_read;

  logic          rst;
  logic          enable;
  logic          empty;
  logic          almost_empty;
  logic [DW-1:0] data_out;
  logic          read_enable;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] rd_count;
  logic          underflow_err;
  rd_state_e     dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fifo_read_ctrl #(.DATA_WIDTH(DW), .SKID_DEPTH(SD), .CNT_WIDTH(CW)) dut (
    .clk_read      (clk_read),
    .rst           (rst),
    .enable        (enable),
    .empty         (empty),
    .almost_empty  (almost_empty),
    .data_out      (data_out),
    .read_enable   (read_enable),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .rd_count      (rd_count),
    .underflow_err (underflow_err),
    .dbg_state     (dbg_state)
  );

  // ---------------- environment FIFO (ideal flags, registered data_out) ----------------
  logic [DW-1:0] env_mem [256];
  int env_wr = 0;
  int env_rd = 0;

  assign empty        = (env_wr == env_rd);
  assign almost_empty = ((env_wr - env_rd) == 1);

  always @(posedge clk_read) begin
    cyc <= cyc + 1;
    if (read_enable && !empty) begin
      data_out <= env_mem[env_rd[7:0]];
      env_rd   <= env_rd + 1;
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] mf_q[$];   // model view of FIFO contents
  logic [DW-1:0] mb_q[$];   // beats visible on the stream, head first
  logic          m_inf    = 1'b0;
  logic [DW-1:0] m_inf_b  = '0;
  logic          m_guard  = 1'b0;
  rd_state_e     m_state  = IDLE;
  logic [CW-1:0] m_count  = '0;

  function automatic logic m_deliver();
    return (mb_q.size() != 0) && m_ready;
  endfunction

  function automatic logic m_re();
    int owed;
    owed = mb_q.size() - int'(m_deliver()) + int'(m_inf);
    return (m_state == STREAM) && (mf_q.size() != 0) && !m_guard && (owed < SD);
  endfunction

  always @(posedge clk_read or negedge rst) begin : model
    logic del;
    logic re;
    if (!rst) begin
      mb_q.delete();
      m_inf   = 1'b0;
      m_guard = 1'b0;
      m_state = IDLE;
      m_count = '0;
    end else begin
      del = m_deliver();
      re  = m_re();
      case (m_state)
        IDLE:    if (enable) m_state = STREAM;
        STREAM:  if (!enable) m_state = DRAIN;
        DRAIN: begin
          if (enable) m_state = STREAM;
          else if (mb_q.size() == 0 && !m_inf) m_state = IDLE;
        end
        default: m_state = IDLE;
      endcase
      if (del) begin
        void'(mb_q.pop_front());
        m_count = m_count + 1'b1;
      end
      if (m_inf) mb_q.push_back(m_inf_b);
      m_guard = re && (mf_q.size() == 1);
      m_inf   = re;
      if (re) m_inf_b = mf_q.pop_front();
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [DW-1:0] got_q[$];
  int            got_c[$];
  int            first_re = -1;
  int            first_v  = -1;

  // Per-cycle compare against the model, plus a monitor of delivered beats.
  always @(negedge clk_read) begin
    if (rst === 1'b1) begin
      chk("read_enable", 32'(read_enable), 32'(m_re()));
      chk("m_valid", 32'(m_valid), 32'(mb_q.size() != 0));
      if (mb_q.size() != 0) chk("m_data", 32'(m_data), 32'(mb_q[0]));
      chk("rd_count", 32'(rd_count), 32'(m_count));
      chk("underflow_err", 32'(underflow_err), 32'd0);
      chk("state", 32'(dbg_state), 32'(m_state));
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        got_c.push_back(cyc);
      end
      if (read_enable && first_re < 0) first_re = cyc;
      if (m_valid && first_v < 0) first_v = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk_read);
    #1;
  endtask

  task automatic preload(input logic [DW-1:0] b);
    env_mem[env_wr[7:0]] = b;
    env_wr = env_wr + 1;
    mf_q.push_back(b);
  endtask

  task automatic do_reset();
    enable  = 1'b0;
    m_ready = 1'b0;
    rst     = 1'b0;
    step(2);
    rst = 1'b1;
    got_q.delete();
    got_c.delete();
    first_re = -1;
    first_v  = -1;
  endtask

  task automatic wait_count(input string name, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (int'(rd_count) == target) break;
      step(1);
    end
    chk(name, 32'(rd_count), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  int  r0;
  int  nx;
  bit  seen;

  initial begin
    data_out = '0;
    // 1: reset held with enable=1
    rst = 1'b0; enable = 1'b1; m_ready = 1'b1;
    step(3);
    chk("rst_read_enable", 32'(read_enable), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_underflow", 32'(underflow_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // 2: sixteen preloaded bytes at full rate
    do_reset();
    for (int i = 0; i < 16; i++) preload(8'(8'h10 + i));
    enable = 1'b1; m_ready = 1'b1;
    wait_count("t2_count", 16, 100);
    step(2);
    chk("t2_beats", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      chk("t2_data", 32'(got_q[i]), 32'(8'h10 + i));
      chk("t2_back_to_back", 32'(got_c[i]), 32'(got_c[0] + i));
    end
    chk("t2_latency", 32'(first_v - first_re), 32'd2);
    chk("t2_rd_count", 32'(rd_count), 32'd16);

    // 3: backpressure from the first beat
    do_reset();
    r0 = env_rd;
    for (int i = 0; i < 4; i++) preload(8'(8'h30 + i));
    m_ready = 1'b0; enable = 1'b1;
    step(10);
    chk("t3_pops", 32'(env_rd - r0), 32'd2);
    chk("t3_valid", 32'(m_valid), 32'd1);
    chk("t3_head", 32'(m_data), 32'h30);
    step(3);
    chk("t3_head_stable", 32'(m_data), 32'h30);
    m_ready = 1'b1;
    wait_count("t3_count", 4, 50);
    step(2);
    chk("t3_beats", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("t3_data", 32'(got_q[i]), 32'(8'h30 + i));

    // 4: last entry pop arms the guard; a refill right after must wait one cycle
    do_reset();
    r0 = env_rd;
    preload(8'hA5);
    enable = 1'b1; m_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_read);
      if (read_enable) begin seen = 1'b1; break; end
    end
    chk("t4_pop_seen", 32'(seen), 32'd1);
    @(posedge clk_read); #1;
    preload(8'h5A);
    @(negedge clk_read);
    chk("t4_guard_blocks", 32'(read_enable), 32'd0);
    chk("t4_fifo_not_empty", 32'(empty), 32'd0);
    step(1);
    wait_count("t4_count", 2, 30);
    step(2);
    chk("t4_pops", 32'(env_rd - r0), 32'd2);
    chk("t4_beats", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      chk("t4_first", 32'(got_q[0]), 32'hA5);
      chk("t4_second", 32'(got_q[1]), 32'h5A);
    end
    chk("t4_underflow", 32'(underflow_err), 32'd0);

    // 5: disable with two buffered and one more popped in the same cycle
    do_reset();
    r0 = env_rd;
    for (int i = 0; i < 3; i++) preload(8'(8'h50 + i));
    m_ready = 1'b0; enable = 1'b1;
    step(8);
    chk("t5_pops_full", 32'(env_rd - r0), 32'd2);
    chk("t5_head", 32'(m_data), 32'h50);
    enable = 1'b0; m_ready = 1'b1;
    step(1);
    chk("t5_pops_at_disable", 32'(env_rd - r0), 32'd3);
    wait_count("t5_count", 3, 30);
    step(3);
    chk("t5_pops_final", 32'(env_rd - r0), 32'd3);
    chk("t5_state", 32'(dbg_state), 32'(IDLE));
    chk("t5_valid", 32'(m_valid), 32'd0);
    if (got_q.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("t5_data", 32'(got_q[i]), 32'(8'h50 + i));
    end else begin
      chk("t5_beats", 32'(got_q.size()), 32'd3);
    end

    // 6: asynchronous reset mid-stream, then resume
    do_reset();
    r0 = env_rd;
    for (int i = 0; i < 8; i++) preload(8'(8'h60 + i));
    enable = 1'b1; m_ready = 1'b1;
    step(4);
    m_ready = 1'b0;
    step(4);
    chk("t6_valid_before", 32'(m_valid), 32'd1);
    chk("t6_count_before_nz", 32'(rd_count != 0), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_read_enable", 32'(read_enable), 32'd0);
    chk("t6_rst_valid", 32'(m_valid), 32'd0);
    chk("t6_rst_count", 32'(rd_count), 32'd0);
    chk("t6_rst_data", 32'(m_data), 32'd0);
    nx = env_rd;
    @(posedge clk_read); #1;
    rst = 1'b1;
    got_q.delete();
    got_c.delete();
    enable = 1'b1; m_ready = 1'b1;
    wait_count("t6_count", 1, 30);
    step(1);
    chk("t6_resume_beats", 32'(got_q.size() != 0), 32'd1);
    if (got_q.size() != 0) chk("t6_resume_data", 32'(got_q[0]), 32'(env_mem[nx[7:0]]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
